// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, drives the instruction SRAM, and produces the IF->ID bus
// plus a stall-safe, bubble-masked instruction word for ID.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   stall[STALL_W]      stall vector (bit0 IF, bit1 ID, bit2 EX; 1 = stop)
//   br_bus[32:0]        {br_e, br_addr} from ID (combinational)
//   if_to_id_bus[32:0]  {ce, pc}
//   inst_sram_*         instruction SRAM port (read only; 1-cycle latency)
//   id_inst[31:0]       instruction word presented to ID
//   fetch_adel          current fetch PC is misaligned
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned STALL_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic [32:0]        br_bus,
  output logic [32:0]        if_to_id_bus,
  output logic               inst_sram_en,
  output logic [3:0]         inst_sram_wen,
  output logic [31:0]        inst_sram_addr,
  output logic [31:0]        inst_sram_wdata,
  input  logic [31:0]        inst_sram_rdata,
  output logic [31:0]        id_inst,
  output logic               fetch_adel
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          br_e;
  logic [AW-1:0] br_addr;
  logic          stall_if;
  logic          stall_id;
  logic          stall_ex;
  logic          stall_unused;
  logic          misalign_c;

  logic [AW-1:0] pc_q, pc_d;
  logic          ce_q, ce_d;
  logic          br_pend_q, br_pend_d;
  logic [AW-1:0] br_tgt_q, br_tgt_d;
  logic          ibuf_v_q, ibuf_v_d;
  logic [DW-1:0] ibuf_q, ibuf_d;
  logic          id_ce_q, id_ce_d;
  logic          id_adel_q, id_adel_d;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign stall_if     = stall[0];
  assign stall_id     = stall[1];
  assign stall_ex     = stall[2];
  assign stall_unused = ^stall;

  assign misalign_c = ce_q & (pc_q[1:0] != 2'b00);

  // Next-state: PC/branch tracking, ID slot mirror and instruction hold buffer
  always_comb begin
    pc_d      = pc_q;
    ce_d      = ce_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    ibuf_v_d  = ibuf_v_q;
    ibuf_d    = ibuf_q;
    id_ce_d   = id_ce_q;
    id_adel_d = id_adel_q;

    // Live branch beats a branch remembered from a stalled cycle
    if (!stall_if) begin
      ce_d      = 1'b1;
      br_pend_d = 1'b0;
      if (br_e) begin
        pc_d = br_addr;
      end else if (br_pend_q) begin
        pc_d = br_tgt_q;
      end else begin
        pc_d = pc_q + AW'(4);
      end
    end else if (br_e) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_addr;
    end

    // The SRAM keeps reading at the held PC during an ID stall, so the word
    // ID owns is captured once on the first stalled cycle.
    if (!stall_id) begin
      id_ce_d   = ce_q;
      id_adel_d = misalign_c;
      ibuf_v_d  = 1'b0;
    end else begin
      if (!stall_ex) begin
        id_ce_d = 1'b0;
      end
      if (!ibuf_v_q) begin
        ibuf_d   = inst_sram_rdata;
        ibuf_v_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC - AW'(4);
      ce_q      <= 1'b0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= '0;
      ibuf_v_q  <= 1'b0;
      ibuf_q    <= '0;
      id_ce_q   <= 1'b0;
      id_adel_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ce_q      <= ce_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
      ibuf_v_q  <= ibuf_v_d;
      ibuf_q    <= ibuf_d;
      id_ce_q   <= id_ce_d;
      id_adel_q <= id_adel_d;
    end
  end

  // Output decode; bus is zeroed until the first valid fetch
  always_comb begin
    if_to_id_bus    = ce_q ? {1'b1, pc_q} : 33'h0;
    inst_sram_en    = ce_q & (pc_q[1:0] == 2'b00);
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = pc_q;
    inst_sram_wdata = 32'h0;
    fetch_adel      = misalign_c;
    // Bubbles and misaligned fetches decode as sll $0,$0,0
    if (!id_ce_q || id_adel_q) begin
      id_inst = 32'h0;
    end else if (ibuf_v_q) begin
      id_inst = ibuf_q;
    end else begin
      id_inst = inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;
  logic        fetch_adel;

  if_fetch_unit #(.RESET_PC(RESET_PC), .STALL_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst),
    .fetch_adel      (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory as a pure function of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F96;
  endfunction

  // SRAM model: 1-cycle read latency; while ID is stalled the read port is
  // deliberately fed junk so any stale-word leak shows up.
  always @(posedge clk) begin
    if (stall[1])          inst_sram_rdata <= 32'hDEAD_BEEF;
    else if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
    else                   inst_sram_rdata <= $urandom;
  end

  typedef struct {
    logic [31:0] addr;
    logic        en;
    logic        adel;
    logic [32:0] bus;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model: architectural PC, a remembered branch, and which
  // instruction (by address) the ID stage currently owns.
  logic [31:0] m_pc      = 32'h0;
  logic        m_ce      = 1'b0;
  logic        m_pend    = 1'b0;
  logic [31:0] m_tgt     = 32'h0;
  logic        m_slot_v  = 1'b0;
  logic [31:0] m_slot_pc = 32'h0;
  logic        m_slot_ad = 1'b0;

  task automatic model_step(input logic r, input logic [5:0] s,
                            input logic be, input logic [31:0] ba);
    logic cur_adel;
    if (r) begin
      m_pc     = RESET_PC - 32'd4;
      m_ce     = 1'b0;
      m_pend   = 1'b0;
      m_slot_v = 1'b0;
      m_slot_ad = 1'b0;
    end else begin
      cur_adel = m_ce && (m_pc % 4 != 0);
      if (!s[1]) begin
        m_slot_v  = m_ce;
        m_slot_pc = m_pc;
        m_slot_ad = cur_adel;
      end else if (!s[2]) begin
        m_slot_v = 1'b0;
      end
      if (!s[0]) begin
        if (be)          m_pc = ba;
        else if (m_pend) m_pc = m_tgt;
        else             m_pc = m_pc + 32'd4;
        m_ce   = 1'b1;
        m_pend = 1'b0;
      end else if (be) begin
        m_pend = 1'b1;
        m_tgt  = ba;
      end
    end
  endtask

  // Apply one cycle of stimulus and queue what the DUT must show after the edge
  task automatic step(input logic r, input logic [5:0] s,
                      input logic be, input logic [31:0] ba);
    exp_t e;
    @(negedge clk);
    rst    = r;
    stall  = s;
    br_bus = {be, ba};
    model_step(r, s, be, ba);
    e.addr = m_pc;
    e.en   = m_ce && (m_pc % 4 == 0);
    e.adel = m_ce && (m_pc % 4 != 0);
    e.bus  = m_ce ? {1'b1, m_pc} : 33'h0;
    e.inst = (m_slot_v && !m_slot_ad) ? mem_word(m_slot_pc) : 32'h0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the active edge
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("sram_addr", 64'(inst_sram_addr), 64'(mon_e.addr));
      chk("sram_en", 64'(inst_sram_en), 64'(mon_e.en));
      chk("fetch_adel", 64'(fetch_adel), 64'(mon_e.adel));
      chk("if_to_id_bus", 64'(if_to_id_bus), 64'(mon_e.bus));
      chk("id_inst", 64'(id_inst), 64'(mon_e.inst));
      chk("sram_wen", 64'(inst_sram_wen), 64'h0);
      chk("sram_wdata", 64'(inst_sram_wdata), 64'h0);
    end
  end

  logic [5:0] stall_pat [6] = '{6'b000000, 6'b000000, 6'b000011,
                                6'b000111, 6'b001111, 6'b111111};

  initial begin
    logic [5:0]  s;
    logic        be;
    logic [31:0] ba;
    int          waited;
    rst    = 1'b1;
    stall  = 6'b0;
    br_bus = 33'h0;

    // Reset, then free-running fetch
    step(1, 6'b0, 0, 0);
    step(1, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // Branch seen while fetching BFC0_0008 (delay slot kept)
    step(0, 6'b0, 1, 32'hBFC0_0100);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // Stall IF+ID with a branch arriving mid-stall
    step(0, 6'b000011, 0, 0);
    step(0, 6'b000011, 1, 32'hBFC0_0200);
    step(0, 6'b000011, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // Hold ID across junk SRAM data
    step(0, 6'b000111, 0, 0);
    step(0, 6'b000111, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // Bubble into EX
    step(0, 6'b000011, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // Misaligned branch target
    step(0, 6'b0, 1, 32'hBFC0_0102);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 1, 32'hBFC0_0300);
    step(0, 6'b0, 0, 0);
    // Pending branch overwritten by a later one, then a live branch on release
    step(0, 6'b000111, 1, 32'hBFC0_0400);
    step(0, 6'b000111, 1, 32'hBFC0_0500);
    step(0, 6'b0, 0, 0);
    step(0, 6'b000011, 1, 32'hBFC0_0600);
    step(0, 6'b0, 1, 32'hBFC0_0700);
    step(0, 6'b0, 0, 0);
    // Reset mid-stall drops the pending branch
    step(0, 6'b000111, 1, 32'hBFC0_0800);
    step(1, 6'b000111, 1, 32'hBFC0_0900);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    // PC wraps past the top of the address space
    step(0, 6'b0, 1, 32'hFFFF_FFF8);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      s  = stall_pat[$urandom_range(0, 5)];
      be = ($urandom_range(0, 5) == 0);
      ba = {16'hBFC0, 6'b0, 10'($urandom_range(0, 1023))} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0)  ba[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) ba = 32'hFFFF_FFF8;
      step(($urandom_range(0, 99) == 0), s, be, ba);
    end
    step(0, 6'b0, 0, 0);
    step(0, 6'b0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF→ID interface.
- Holds the PC and drives the instruction SRAM. Consumes the branch bus from ID and drives the 33-bit IF→ID bus {ce, pc}.
- Supplies ID with a stall-safe, bubble-masked instruction word, so a stall or an injected ID bubble never exposes a stale or wrong SRAM word.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetched instruction after reset.
- STALL_W, 6, width of the stall bus. Bit 0 = IF, bit 1 = ID, bit 2 = EX; 1 = Stop.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  STALL_W  pipeline stall vector from ctrl
- br_bus  in  33  {br_e, br_addr[31:0]}, combinational from ID
- if_to_id_bus  out  33  {ce, pc[31:0]}
- inst_sram_en  out  1  SRAM read enable
- inst_sram_wen  out  4  byte write enables; always 0
- inst_sram_addr  out  32  fetch address
- inst_sram_wdata  out  32  always 0
- inst_sram_rdata  in  32  read data; valid 1 cycle after en/addr
- id_inst  out  32  instruction word for the ID stage
- fetch_adel  out  1  PC misaligned on current fetch

Behaviour:
Reset:
- Reset is clk with rst, synchronous, active-high.
- pc_reg <= RESET_PC-4, ce_reg <= 0, br_pend <= 0, ibuf_v <= 0, id_ce <= 0.
- Resulting outputs during reset: inst_sram_en=0, if_to_id_bus=0, id_inst=0, fetch_adel=0.
- First cycle after rst deasserts: ce_reg=1, pc_reg=RESET_PC.

PC update:
- Occurs only when stall[0]==0:
  - ce_reg <= 1.
  - pc_reg <= br_e ? br_addr : br_pend ? br_tgt : pc_reg+4.
  - br_pend <= 0.
- When stall[0]==1: pc_reg and ce_reg hold.
- Branch arriving under stall: if br_e=1 while stall[0]==1, then br_pend <= 1 and br_tgt <= br_addr. A later live br_e overwrites br_tgt.
- Priority: live br_e > br_pend > pc+4.
- Addition wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).

SRAM interface:
- inst_sram_addr = pc_reg.
- inst_sram_en = ce_reg & (pc_reg[1:0]==0).
- fetch_adel = ce_reg & (pc_reg[1:0]!=0). It is a flag only; the PC still advances.
- wen and wdata are constant 0.

ID slot tracker:
- id_ce mirrors the ID input register update rule:
  - rst → 0.
  - stall[1]==1 && stall[2]==0 → 0 (bubble).
  - stall[1]==0 → ce_reg, and also captures fetch_adel into id_adel.
  - otherwise hold.

Instruction hold buffer:
- First cycle with stall[1]==1 and ibuf_v==0: ibuf <= inst_sram_rdata, ibuf_v <= 1.
- First cycle with stall[1]==0: ibuf_v <= 0.
- id_inst = !id_ce || id_adel ? 32'h0 : ibuf_v ? ibuf : inst_sram_rdata.
- A bubble or misaligned fetch therefore decodes as sll $0,$0,0.

Simultaneous events:
- rst dominates stall and br_e.
- A bubble (stall[1]=1, stall[2]=0) coincident with br_e: the branch is still recorded (pending or applied).
- Reset mid-stall clears br_pend and ibuf_v; no pending branch survives reset.

Latency:
- Fetch address to id_inst: 1 cycle.
- Branch resolved in ID → target on inst_sram_addr the next unstalled cycle. The delay-slot instruction is the word already fetched at pc+4 and is not squashed.

Test Plan:
- Reset release, no stalls → inst_sram_addr sequence BFC0_0000, BFC0_0004, BFC0_0008; if_to_id_bus.ce=1 from cycle 1; id_inst equals rdata of the previous address.
- br_bus={1, 32'hBFC0_0100} for one cycle at pc=BFC0_0008 → next address BFC0_0100; the BFC0_0008 word (delay slot) reaches ID unmodified.
- stall=6'b000011 for 3 cycles with br_e pulsed in the 2nd cycle to BFC0_0200 → PC held; after release, next address BFC0_0200; br_pend cleared.
- stall[1]=1 for 2 cycles while the SRAM model changes rdata to 32'hDEAD_BEEF → id_inst keeps the pre-stall word until release.
- stall=6'b000011 (bubble into EX) → next cycle with stall[1]=0 delivers valid word; during the bubble id_ce=0 and id_inst=0.
- br_addr=32'hBFC0_0102 → fetch_adel=1, inst_sram_en=0, id_inst=0 one cycle later; PC then advances to BFC0_0106.
